// File: rtl/ufp_sched_pkg.sv
// Shared types and the fixed-point multiply helper for the ufp_mul_sched multiplier scheduler.
// Latency: not applicable (types, constants and a combinational function only).
// Backpressure: not applicable. Configure N_REQ/IW/QW/LAT here; every user picks them up.
package ufp_sched_pkg;

   localparam int N_REQ = 4;              // requesters sharing the multiplier (2..8)
   localparam int IW    = 16;             // integer bits
   localparam int QW    = 16;             // fraction bits
   localparam int LAT   = 2;              // grant edge to rsp_valid, in cycles (>= 2)
   localparam int W     = IW + QW;
   localparam int TAG_W = $clog2(N_REQ);

   typedef logic [TAG_W-1:0] tag_t;

   // Operand register stage, tagged with the requester it belongs to.
   typedef struct packed {
      logic         v;
      tag_t         tag;
      logic         clip;
      logic [W-1:0] x;
      logic [W-1:0] y;
   } pipe_stage_t;

   // Result travelling towards the per-requester slots.
   typedef struct packed {
      logic         v;
      tag_t         tag;
      logic         ovf;
      logic [W-1:0] data;
   } result_t;

   // Unsigned Q(IW).(QW) multiply: returns {overflow, result}.
   // The fraction is truncated; bits above the result window signal overflow,
   // which saturates to all ones when clip is set and wraps otherwise.
   function automatic logic [W:0] ufp_mul(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic         clip);
      logic [2*W-1:0] p;
      logic           ovf;
      logic [W-1:0]   r;
      p   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      ovf = |p[2*W-1:QW+W];
      r   = (ovf && clip) ? {W{1'b1}} : p[QW+W-1:QW];
      return {ovf, r};
   endfunction

endpackage

// File: rtl/ufp_rr_arbiter.sv
// N-way round-robin arbiter: scans eligible from ptr upward (mod N), returns one-hot grant.
// Latency: purely combinational; ptr_nxt is the slot after the winner, or ptr when no grant.
// Backpressure: none; the caller masks requesters that cannot accept work out of eligible.
// Ports: eligible (in, N), ptr (in), grant (out, one-hot or zero), gnt_idx/gnt_vld/ptr_nxt (out).
module ufp_rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         eligible,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic                 gnt_vld,
   output logic [$clog2(N)-1:0] ptr_nxt
);

   localparam int TW = $clog2(N);

   always_comb begin
      int j;
      grant   = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!gnt_vld && eligible[j]) begin
            gnt_vld    = 1'b1;
            grant[j]   = 1'b1;
            gnt_idx    = TW'(j);
         end
      end
      // Explicit wrap so non-power-of-two N stays inside 0..N-1.
      ptr_nxt = ptr;
      if (gnt_vld) begin
         ptr_nxt = (gnt_idx == TW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/ufp_mul_sched.sv
// Shares one unsigned fixed-point multiplier between N_REQ requesters via round-robin grants.
// Latency: LAT cycles from the grant edge to the result appearing in the requester's slot.
// Backpressure: one op outstanding per requester; a full result slot blocks new grants to it,
//   so the multiply pipeline itself never stalls.
// Ports: req_valid/req_ready/req_x/req_y/req_clip request side (slice i at [i*W +: W]);
//   rsp_valid/rsp_ready/rsp_data/rsp_clipped per-requester result slots; busy = work in flight.
module ufp_mul_sched
   import ufp_sched_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   output logic [N_REQ-1:0]   req_ready,
   input  logic [N_REQ*W-1:0] req_x,
   input  logic [N_REQ*W-1:0] req_y,
   input  logic [N_REQ-1:0]   req_clip,
   output logic [N_REQ-1:0]   rsp_valid,
   input  logic [N_REQ-1:0]   rsp_ready,
   output logic [N_REQ*W-1:0] rsp_data,
   output logic [N_REQ-1:0]   rsp_clipped,
   output logic               busy
);

   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] grant;
   logic             gnt_vld;
   tag_t             gnt_idx;
   tag_t             ptr;
   tag_t             ptr_nxt;
   pipe_stage_t      s0;
   result_t          mul_res;
   result_t          res_q;
   logic             dly_busy;

   // Registered rsp_valid here means a slot consumed this cycle is only re-granted next cycle.
   assign eligible = req_valid & ~pending & ~rsp_valid;

   ufp_rr_arbiter #(.N(N_REQ)) u_arb (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (grant),
      .gnt_idx  (gnt_idx),
      .gnt_vld  (gnt_vld),
      .ptr_nxt  (ptr_nxt)
   );

   // Held low while reset is asserted so nothing looks accepted during reset.
   assign req_ready = grant & {N_REQ{rst_n}};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
         s0  <= '0;
      end else begin
         ptr  <= ptr_nxt;
         s0.v <= gnt_vld;
         if (gnt_vld) begin
            s0.tag  <= gnt_idx;
            s0.clip <= req_clip[gnt_idx];
            s0.x    <= req_x[int'(gnt_idx)*W +: W];
            s0.y    <= req_y[int'(gnt_idx)*W +: W];
         end
      end
   end

   always_comb begin
      mul_res                = '0;
      mul_res.v              = s0.v;
      mul_res.tag            = s0.tag;
      {mul_res.ovf, mul_res.data} = ufp_mul(s0.x, s0.y, s0.clip);
   end

   // Extra latency beyond operand reg + slot reg is plain delay on the result.
   if (LAT == 2) begin : g_nodly
      assign res_q    = mul_res;
      assign dly_busy = 1'b0;
   end else begin : g_dly
      result_t dly [LAT-2];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < LAT-2; k++) dly[k] <= '0;
         end else begin
            dly[0] <= mul_res;
            for (int k = 1; k < LAT-2; k++) dly[k] <= dly[k-1];
         end
      end

      always_comb begin
         dly_busy = 1'b0;
         for (int k = 0; k < LAT-2; k++) dly_busy = dly_busy | dly[k].v;
      end

      assign res_q = dly[LAT-3];
   end

   // Slot write and pending clear coincide; a slot being written is never valid
   // (its owner was pending), so write and consume of the same slot cannot collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending     <= '0;
         rsp_valid   <= '0;
         rsp_data    <= '0;
         rsp_clipped <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (res_q.v && res_q.tag == tag_t'(i)) begin
               pending[i]          <= 1'b0;
               rsp_valid[i]        <= 1'b1;
               rsp_data[i*W +: W]  <= res_q.data;
               rsp_clipped[i]      <= res_q.ovf;
            end else begin
               if (grant[i]) pending[i] <= 1'b1;
               if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   assign busy = s0.v | dly_busy | (|rsp_valid);

endmodule

// File: tb/tb_ufp_mul_sched.sv
// Self-checking bench for ufp_mul_sched: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of grants, slots and products.
module tb_ufp_mul_sched;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_x = '0;
   logic [N*W-1:0] req_y = '0;
   logic [N-1:0]   req_clip = '0;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready = '0;
   logic [N*W-1:0] rsp_data;
   logic [N-1:0]   rsp_clipped;
   logic           busy;

   always #5 clk = ~clk;

   ufp_mul_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_clip    (req_clip),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_clipped (rsp_clipped),
      .busy        (busy)
   );

   int passed = 0;
   int total  = 0;

   // Reference model state: per-requester outstanding op and result slot.
   bit          m_pend   [N];
   int          m_land   [N];
   bit          m_slot_v [N];
   logic [31:0] m_slot_d [N];
   bit          m_slot_c [N];
   logic [31:0] m_exp_d  [N];
   bit          m_exp_c  [N];
   int          m_ptr = 0;
   int          cyc = 0;
   int          grants_seen = 0;

   function automatic logic [32:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                           input logic clip);
      logic [63:0] p;
      logic        ovf;
      p   = {32'd0, x} * {32'd0, y};
      ovf = (p >> 48) != 64'd0;
      if (ovf && clip) return {1'b1, 32'hFFFF_FFFF};
      return {ovf, 32'(p >> 16)};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         m_pend[i]   = 1'b0;
         m_land[i]   = 0;
         m_slot_v[i] = 1'b0;
         m_slot_d[i] = '0;
         m_slot_c[i] = 1'b0;
      end
      m_ptr = 0;
   endtask

   // Called at posedge+1 with inputs for this cycle already driven.
   task automatic step();
      int           g;
      logic [N-1:0] er;
      logic [N-1:0] ev;
      bit           bz;
      logic [32:0]  r;
      #1;
      g = -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (g < 0 && req_valid[j] && !m_pend[j] && !m_slot_v[j]) g = j;
      end
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      ev = '0;
      bz = 1'b0;
      for (int i = 0; i < N; i++) begin
         ev[i] = m_slot_v[i];
         bz    = bz | m_pend[i] | m_slot_v[i];
      end
      chk("req_ready", req_ready, er);
      chk("rsp_valid", rsp_valid, ev);
      for (int i = 0; i < N; i++) begin
         if (m_slot_v[i]) begin
            chk("rsp_data", rsp_data[i*W +: W], m_slot_d[i]);
            chk("rsp_clipped", rsp_clipped[i], m_slot_c[i]);
         end
      end
      chk("busy", busy, bz);
      grants_seen += $countones(req_ready & req_valid);
      // Advance the model across the coming edge: consume, land, then grant.
      for (int i = 0; i < N; i++) begin
         if (m_slot_v[i] && rsp_ready[i]) m_slot_v[i] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         if (m_pend[i] && m_land[i] == cyc + 1) begin
            m_pend[i]   = 1'b0;
            m_slot_v[i] = 1'b1;
            m_slot_d[i] = m_exp_d[i];
            m_slot_c[i] = m_exp_c[i];
         end
      end
      if (g >= 0) begin
         m_pend[g] = 1'b1;
         m_land[g] = cyc + LAT;
         r = ref_mul(req_x[g*W +: W], req_y[g*W +: W], req_clip[g]);
         m_exp_c[g] = r[32];
         m_exp_d[g] = r[31:0];
         m_ptr = (g + 1) % N;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Asserts reset away from the clock edge and checks outputs clear immediately.
   task automatic do_reset();
      req_valid = '1;
      rst_n = 1'b0;
      #1;
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_rsp_clipped", rsp_clipped, 0);
      model_clear();
      req_valid = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One isolated op on requester i with constant expectations.
   task automatic single_op(input int i, input logic [31:0] x, input logic [31:0] y,
                            input logic clip, input logic [31:0] exp_d, input logic exp_c);
      req_x[i*W +: W] = x;
      req_y[i*W +: W] = y;
      req_clip[i]     = clip;
      req_valid[i]    = 1'b1;
      step();
      req_valid[i] = 1'b0;
      chk("op_not_yet", rsp_valid[i], 1'b0);
      step();
      chk("op_valid_at_lat", rsp_valid[i], 1'b1);
      chk("op_data", rsp_data[i*W +: W], exp_d);
      chk("op_clipped", rsp_clipped[i], exp_c);
      rsp_ready[i] = 1'b1;
      step();
      rsp_ready[i] = 1'b0;
   endtask

   initial begin
      int          g0;
      bit          seen;
      logic [32:0] r;

      do_reset();
      step();

      // Basic multiply, overflow in both modes, fraction truncation.
      single_op(0, 32'h0001_0000, 32'h0002_0000, 1'b0, 32'h0002_0000, 1'b0);
      single_op(2, 32'h0100_0000, 32'h0100_0000, 1'b1, 32'hFFFF_FFFF, 1'b1);
      single_op(3, 32'h0100_0000, 32'h0100_0000, 1'b0, 32'h0000_0000, 1'b1);
      single_op(1, 32'h0000_8000, 32'h0000_0001, 1'b1, 32'h0000_0000, 1'b0);

      // All requesters streaming with free result path: one grant every cycle.
      rsp_ready = '1;
      req_valid = '1;
      g0 = grants_seen;
      for (int c = 0; c < 16; c++) begin
         for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = $urandom >> $urandom_range(0, 16);
            req_y[i*W +: W] = $urandom >> $urandom_range(0, 16);
            req_clip[i]     = 1'($urandom);
         end
         step();
      end
      chk("stream_grants", grants_seen - g0, 16);
      req_valid = '0;
      repeat (3) step();

      // Requester 1 holds its result; others keep being served.
      rsp_ready = 4'b1101;
      req_valid = '1;
      repeat (6) step();
      g0 = grants_seen;
      for (int c = 0; c < 10; c++) begin
         chk("bp_slot1_held", rsp_valid[1], 1'b1);
         chk("bp_no_grant1", req_ready[1], 1'b0);
         step();
      end
      chk("bp_others_served", (grants_seen - g0) >= 8, 1'b1);
      rsp_ready = '1;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (req_ready[1]) seen = 1'b1;
      end
      chk("bp_regrant1", seen, 1'b1);
      req_valid = '0;
      repeat (3) step();

      // Reset with one op in the pipeline and one result waiting in its slot.
      rsp_ready = '0;
      req_valid = 4'b0011;
      step();
      step();
      do_reset();
      repeat (4) step();
      chk("post_rst_idle", rsp_valid, 0);
      r = ref_mul(32'h0003_4000, 32'h0002_8000, 1'b0);
      single_op(1, 32'h0003_4000, 32'h0002_8000, 1'b0, r[31:0], r[32]);

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         rsp_ready = N'($urandom);
         for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = $urandom >> $urandom_range(0, 24);
            req_y[i*W +: W] = $urandom >> $urandom_range(0, 24);
            req_clip[i]     = 1'($urandom);
         end
         step();
      end
      req_valid = '0;
      rsp_ready = '1;
      repeat (4) step();
      chk("final_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
